// File: rtl/col_decoder.sv
// col_decoder: keypad column decoder working against an external row sweeper.
// The raw columns are synchronised and the row drive is delayed to match.
// A press on the tracked key is debounced, then reported as a code.
// The row sweeper is frozen while a key is tracked.
// Optional macro COL_DECODER_HEX_MAP_EN selects the hex legend for key codes.
// Without the macro, the key code is the raw row*4+col value.
//
// Handshake: key_valid is a one-cycle pulse with no ready/backpressure. Key is
// valid in that cycle and holds its value until the next confirmed press.
// dbg_state exposes the FSM state (0 IDLE, 1 DEBOUNCE, 2 HELD, 3 RELEASE).
module col_decoder #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic [3:0] cols,
    output logic       stop,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Synchroniser stage and matching row delay.
    logic [3:0] col_m_q, col_s_q;
    logic [3:0] row_m_q, row_d_q;

    // FSM state and datapath registers.
    state_t     state_q, state_d;
    logic [3:0] lr_q, lr_d;
    logic [1:0] lc_q, lc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] key_q, key_d;
    logic       key_valid_q, key_valid_d;

    logic       aligned;
    logic       col_hit;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
    endfunction

    function automatic logic [1:0] low_col(input logic [3:0] c);
        if (c[0])      return 2'd0;
        else if (c[1]) return 2'd1;
        else if (c[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [1:0] row_idx(input logic [3:0] r);
        case (r)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] enc_key(input logic [3:0] r, input logic [1:0] c);
        logic [3:0] raw;
        raw = {row_idx(r), c};
`ifdef COL_DECODER_HEX_MAP_EN
        case (raw)
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'hE;
            4'd13:   return 4'h0;
            4'd14:   return 4'hF;
            default: return 4'hD;
        endcase
`else
        return raw;
`endif
    endfunction

    // Two-flop column synchroniser with a matching two-stage row delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_m_q <= 4'b0;
            col_s_q <= 4'b0;
            row_m_q <= 4'b0;
            row_d_q <= 4'b0;
        end else begin
            col_m_q <= cols;
            col_s_q <= col_m_q;
            row_m_q <= rows;
            row_d_q <= row_m_q;
        end
    end

    assign aligned = (row_d_q == lr_q);
    assign col_hit = col_s_q[lc_q];

    // Next-state logic: only cycles where the delayed row matches the latched row count.
    always_comb begin
        state_d     = state_q;
        lr_d        = lr_q;
        lc_d        = lc_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ((col_s_q != 4'b0) && is_onehot(row_d_q)) begin
                    lr_d    = row_d_q;
                    lc_d    = low_col(col_s_q);
                    cnt_d   = 8'd0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (aligned) begin
                    if (col_hit) begin
                        if (cnt_q >= CNT_LAST) begin
                            key_d       = enc_key(lr_q, lc_q);
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HELD: begin
                if (aligned && !col_hit) begin
                    cnt_d   = 8'd0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (aligned) begin
                    if (col_hit) begin
                        state_d = HELD;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lr_q        <= 4'b0;
            lc_q        <= 2'd0;
            cnt_q       <= 8'd0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lr_q        <= lr_d;
            lc_q        <= lc_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Freeze the sweeper once it reaches the latched row while a key is tracked.
    always_comb begin
        stop = (state_q != IDLE) && (rows == lr_q);
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign dbg_state = state_q;

endmodule

// File: doc/col_decoder.md
COL_DECODER -- requirements
Module: col_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8, means the number of aligned sampled cycles needed to confirm a press or release; legal range is 2..255.
REQ-002 clk  input  1  is the single clock; every register is clocked on the rising edge.
REQ-003 reset  input  1  is an asynchronous, active-high reset.
REQ-004 rows  input  4  is the one-hot row drive from the row sweeper (bit n means row n is driven).
REQ-005 cols  input  4  is the raw, asynchronous keypad columns; they are active-high and bit n means column n is connected to the driven row.
REQ-006 stop  output  1  freezes the row sweeper while high.
REQ-007 key  output  4  is the code of the last confirmed key.
REQ-008 key_valid  output  1  is a one-cycle pulse marking a new confirmed key.

Function
REQ-009 cols SHALL pass through a 2-flop synchronizer; rows SHALL pass through a matching 2-stage delay so that row_d and col_s stay aligned.
REQ-010 The FSM SHALL have four states, IDLE, DEBOUNCE, HELD and RELEASE, and every output SHALL be registered except stop.
REQ-011 In IDLE: if col_s != 0 and row_d is one-hot, the FSM latches lr=row_d and lc=lowest set bit of col_s, clears the counter, and moves to DEBOUNCE.
REQ-012 In IDLE: if row_d is not one-hot (zero or multi-hot), any column activity SHALL be ignored.
REQ-013 An aligned cycle is one where row_d == lr; non-aligned cycles SHALL hold the counter and SHALL NOT change state.
REQ-014 In DEBOUNCE: an aligned cycle with col_s[lc]=1 increments the counter; an aligned cycle with col_s[lc]=0 returns to IDLE with no output.
REQ-015 In DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES-1 and the current aligned cycle has col_s[lc]=1, the next edge SHALL load key, pulse key_valid for exactly 1 cycle, and move to HELD.
REQ-016 In HELD: an aligned cycle with col_s[lc]=0 moves to RELEASE with the counter cleared; otherwise the FSM stays in HELD.
REQ-017 In RELEASE: an aligned cycle with col_s[lc]=1 returns to HELD; an aligned cycle with col_s[lc]=0 increments the counter; reaching DEBOUNCE_CYCLES-1 moves to IDLE.
REQ-018 stop SHALL be combinational: 1 when state != IDLE and rows == lr, 0 otherwise. The sweeper keeps cycling until it reaches the latched row and then freezes there; no combinational loop exists.
REQ-019 Key code without the macro: key = {row index, column index}, i.e. row*4+col.
REQ-020 Presses on other keys while the FSM is outside IDLE SHALL be ignored; only lc of lr is tracked.
REQ-021 Press-to-key_valid latency SHALL be 2 synchronizer cycles plus the row realignment time plus DEBOUNCE_CYCLES aligned cycles.
REQ-022 key SHALL hold its value until the next confirmed press.
REQ-023 The counter SHALL saturate and SHALL never wrap.

Reset
REQ-024 Asserting reset at any time, including mid-debounce, SHALL force: state=IDLE, synchronizer and delay flops=0, lr=0, lc=0, counter=0, key=4'h0, key_valid=0, and therefore stop=0.
REQ-025 After reset deasserts, the first transition SHALL occur no earlier than the 3rd rising edge.

Configuration
REQ-026 Macro COL_DECODER_HEX_MAP_EN SHALL control key encoding.
REQ-027 When COL_DECODER_HEX_MAP_EN is defined, key SHALL be the hex legend:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D (* = E, # = F)
REQ-028 When COL_DECODER_HEX_MAP_EN is undefined, key SHALL be the raw row*4+col code per REQ-019.

Verification
REQ-029 With the sweeper model running, hold row1/col2 for 40 cycles -> exactly one key_valid pulse; key=4'h6 (raw) or 4'h6 (hex); stop stays high with rows=4'b0010 until release.
REQ-030 Press row0/col0 for 3 aligned cycles, then release (DEBOUNCE_CYCLES=8) -> no key_valid; FSM returns to IDLE; stop=0.
REQ-031 Hold row3/col1 and bounce col1 low for 2 cycles during HELD -> no second key_valid pulse; a clean release of 8 cycles reaches IDLE.
REQ-032 Assert cols=4'b1010 on row2 -> lc=1; key=4'h9 (raw) or 4'h8 (hex).
REQ-033 Assert reset during DEBOUNCE after 5 counts -> next cycle shows stop=0, key_valid=0, key=0, state IDLE.
REQ-034 Present rows=4'b0000 with cols=4'b0001 for 20 cycles -> no state change and no key_valid.
